// File: rtl/temp_conv_pkg.sv
// rtl/temp_conv_pkg.sv - shared types and constants for the Celsius-to-Fahrenheit converter
package temp_conv_pkg;

  // Conversion sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  localparam int MUL_K      = 9;
  localparam int DIV_K      = 5;
  localparam int F_OFFSET   = 32;
  localparam int DIVIDEND_W = 11;
  localparam int OUT_W      = 10;

  localparam int IN_W       = 8;
  localparam int DIVISOR_W  = 3;
  localparam int ITER_W     = 4;
  localparam int COUNT_W    = 16;

  // Number of divider iterations minus one; the counter runs down to zero
  localparam int DIV_LAST   = DIVIDEND_W - 1;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 11-bit by 3-bit unsigned restoring divider, one quotient bit per cycle
module seq_divider
  import temp_conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  done_o,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o
);

  logic                  busy_q;
  logic [ITER_W-1:0]     cnt_q;
  // Holds the not-yet-consumed dividend bits at the top and the quotient
  // bits shifting in from the bottom; after the last step it is the quotient.
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;

  logic [DIVISOR_W:0]    partial;
  logic [DIVISOR_W:0]    diff;
  logic                  ge;
  logic [DIVISOR_W-1:0]  rem_d;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    partial = {rem_q, quo_q[DIVIDEND_W-1]};
    diff    = partial - {1'b0, divisor_i};
    ge      = (partial >= {1'b0, divisor_i});
    rem_d   = ge ? diff[DIVISOR_W-1:0] : partial[DIVISOR_W-1:0];
  end

  // Load on start, then one restoring step per cycle until the count hits zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= ITER_W'(DIV_LAST);
      quo_q  <= dividend_i;
      rem_q  <= '0;
    end else if (busy_q) begin
      quo_q <= {quo_q[DIVIDEND_W-2:0], ge};
      rem_q <= rem_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Done marks the cycle whose edge performs the final iteration
  always_comb begin
    done_o      = busy_q && (cnt_q == '0);
    quotient_o  = quo_q;
    remainder_o = rem_q;
  end

endmodule

// File: rtl/temp_conv_seq.sv
// rtl/temp_conv_seq.sv - sequential Celsius-to-Fahrenheit converter with valid/ready handshakes
module temp_conv_seq
  import temp_conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    celsius_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   fahrenheit_out,
  output logic [COUNT_W-1:0] conv_count
);

  state_e                state_q, state_d;
  logic                  sign_q;
  logic [IN_W-1:0]       mag_q;
  logic [OUT_W-1:0]      f_q;
  logic [COUNT_W-1:0]    conv_count_q;

  logic                  accept;
  logic                  div_start;
  logic                  div_done;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  div_unused_rem;
  logic                  div_unused_msb;
  logic [OUT_W-1:0]      q_trunc;
  logic [OUT_W-1:0]      f_fix;

  // |C| * 9 never exceeds 1152, so the 11-bit dividend cannot overflow
  always_comb begin
    dividend = DIVIDEND_W'(mag_q) * DIVIDEND_W'(MUL_K);
  end

  seq_divider u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (dividend),
    .divisor_i   (DIVISOR_W'(DIV_K)),
    .done_o      (div_done),
    .quotient_o  (quotient),
    .remainder_o (div_unused_rem)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_MUL;
      S_MUL:                  state_d = S_DIV;
      S_DIV:   if (div_done)  state_d = S_FIX;
      S_FIX:                  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Handshake and divider-start decode, purely from the state register
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_OUT);
    div_start = (state_q == S_MUL);
  end

  assign accept = in_ready && in_valid;

  // Capture sign and magnitude only on the accept edge; -128 maps to magnitude 128
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
      mag_q  <= '0;
    end else if (accept) begin
      sign_q <= celsius_in[IN_W-1];
      mag_q  <= celsius_in[IN_W-1] ? (IN_W'(0) - celsius_in) : celsius_in;
    end
  end

  // Quotient is at most 230, so it fits the result width before the sign is applied
  always_comb begin
    q_trunc        = quotient[OUT_W-1:0];
    div_unused_msb = quotient[DIVIDEND_W-1];
    f_fix          = (sign_q ? (OUT_W'(0) - q_trunc) : q_trunc) + OUT_W'(F_OFFSET);
  end

  // Result register, loaded in FIX and held through OUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_q <= '0;
    end else if (state_q == S_FIX) begin
      f_q <= f_fix;
    end
  end

  // Delivered-result counter, saturating at all ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conv_count_q <= '0;
    end else if (out_valid && out_ready && (conv_count_q != {COUNT_W{1'b1}})) begin
      conv_count_q <= conv_count_q + 1'b1;
    end
  end

  assign fahrenheit_out = f_q;
  assign conv_count     = conv_count_q;

endmodule

// File: tb/tb_temp_conv_seq.sv
// tb/tb_temp_conv_seq.sv - randomized self-checking bench for temp_conv_seq
module tb_temp_conv_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  celsius_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  fahrenheit_out;
  logic [15:0] conv_count;

  int checks;
  int errors;
  int exp_count;

  temp_conv_seq dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .celsius_in     (celsius_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fahrenheit_out (fahrenheit_out),
    .conv_count     (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer division in SV truncates toward zero
  function automatic int model_f(input int c);
    return (c * 9) / 5 + 32;
  endfunction

  function automatic int f_as_int(input logic [9:0] f);
    return int'($signed(f));
  endfunction

  // Accept one sample and wait for out_valid with out_ready held low
  task automatic run_conv(input logic [7:0] c, output int f, output int lat, output logic rdy);
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    celsius_in = c;
    rdy        = in_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid   = 1'b0;
    celsius_in = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    f = f_as_int(fahrenheit_out);
  endtask

  // Consume the pending result; returns on the negedge after the handshake edge
  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    celsius_in = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    checks++;
    if (fahrenheit_out !== 10'd0 || conv_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs f=%0d count=%0d required 0/0", fahrenheit_out, conv_count);
    end
    rst = 1'b1;
    exp_count = 0;
  endtask

  task automatic test_zero();
    int f, lat;
    logic rdy;
    run_conv(8'd0, f, lat, rdy);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL zero_in_ready got %b required 1", rdy);
    end
    checks++;
    if (lat !== 13) begin
      errors++;
      $display("FAIL zero_latency got %0d required 13", lat);
    end
    checks++;
    if (f !== 32) begin
      errors++;
      $display("FAIL zero_result got %0d required 32", f);
    end
    take_out();
    exp_count++;
    checks++;
    if (conv_count !== 16'(exp_count) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_count got %0d/%b required %0d/1", conv_count, in_ready, exp_count);
    end
  endtask

  task automatic test_sweep();
    int cs[5] = '{100, -40, 37, 127, -128};
    int fs[5] = '{212, -40, 98, 260, -198};
    int f, lat;
    logic rdy;
    for (int i = 0; i < 5; i++) begin
      run_conv(8'(cs[i]), f, lat, rdy);
      checks++;
      if (f !== fs[i] || lat !== 13) begin
        errors++;
        $display("FAIL sweep c=%0d got f=%0d lat=%0d required f=%0d lat=13", cs[i], f, lat, fs[i]);
      end
      take_out();
      exp_count++;
    end
    checks++;
    if (conv_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL sweep_count got %0d required %0d", conv_count, exp_count);
    end
  endtask

  task automatic test_random();
    int f, lat, c, e;
    logic rdy;
    for (int i = 0; i < 16; i++) begin
      c = int'($signed(8'($urandom)));
      e = model_f(c);
      run_conv(8'(c), f, lat, rdy);
      checks++;
      if (f !== e || lat !== 13 || rdy !== 1'b1) begin
        errors++;
        $display("FAIL random c=%0d got f=%0d lat=%0d rdy=%b required f=%0d lat=13 rdy=1",
                 c, f, lat, rdy, e);
      end
      take_out();
      exp_count++;
    end
  endtask

  task automatic test_hold();
    int f, lat, bad;
    logic rdy;
    run_conv(8'($signed(-17)), f, lat, rdy);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f_as_int(fahrenheit_out) !== model_f(-17) || in_ready !== 1'b0 ||
          out_valid !== 1'b1 || conv_count !== 16'(exp_count)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable bad_cycles=%0d required 0 (f=%0d count=%0d)", bad,
               f_as_int(fahrenheit_out), conv_count);
    end
    take_out();
    exp_count++;
    checks++;
    if (conv_count !== 16'(exp_count) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release count=%0d in_ready=%b required %0d/1", conv_count, in_ready, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int last_acc, n_acc, n_out, bad_sp, bad_val, e;
    last_acc = -1; n_acc = 0; n_out = 0; bad_sp = 0; bad_val = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) bad_val++;
        else begin
          e = exp_q.pop_front();
          if (f_as_int(fahrenheit_out) !== e) bad_val++;
        end
      end
      celsius_in = 8'($urandom);
      if (in_ready) begin
        if (last_acc >= 0 && cyc - last_acc != 15) bad_sp++;
        last_acc = cyc;
        exp_q.push_back(model_f(int'($signed(celsius_in))));
        n_acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      if (out_valid) begin
        n_out++;
        e = exp_q.pop_front();
        if (f_as_int(fahrenheit_out) !== e) bad_val++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    exp_count += n_acc;
    checks++;
    if (bad_val !== 0 || exp_q.size() !== 0 || n_out !== n_acc) begin
      errors++;
      $display("FAIL b2b_values bad=%0d left=%0d outs=%0d accepts=%0d required 0/0/equal",
               bad_val, exp_q.size(), n_out, n_acc);
    end
    checks++;
    if (bad_sp !== 0 || n_acc < 6) begin
      errors++;
      $display("FAIL b2b_spacing bad=%0d accepts=%0d required 0 and >=6", bad_sp, n_acc);
    end
    checks++;
    if (conv_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL b2b_count got %0d required %0d", conv_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    int f, lat, seen;
    logic rdy;
    @(negedge clk);
    in_valid   = 1'b1;
    celsius_in = 8'd77;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    exp_count = 0;
    checks++;
    if (out_valid !== 1'b0 || fahrenheit_out !== 10'd0 || conv_count !== 16'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async out_valid=%b f=%0d count=%0d in_ready=%b required 0/0/0/1",
               out_valid, fahrenheit_out, conv_count, in_ready);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got %b required 1", in_ready);
    end
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || conv_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_abort out_valid_cycles=%0d count=%0d required 0/0", seen, conv_count);
    end
    run_conv(8'($signed(-5)), f, lat, rdy);
    checks++;
    if (f !== 23 || lat !== 13) begin
      errors++;
      $display("FAIL rstmid_next got f=%0d lat=%0d required 23/13", f, lat);
    end
    take_out();
    exp_count++;
  endtask

  task automatic test_saturate();
    int f, lat;
    logic rdy;
    @(negedge clk);
    force dut.conv_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.conv_count_q;
    exp_count = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      run_conv(8'($urandom), f, lat, rdy);
      take_out();
      if (exp_count < 32'hFFFF) exp_count++;
      checks++;
      if (conv_count !== 16'(exp_count)) begin
        errors++;
        $display("FAIL saturate step=%0d got %h required %h", i, conv_count, 16'(exp_count));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (conv_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturate_hold got %h required ffff", conv_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    celsius_in = 8'h00;
    test_reset();
    test_zero();
    test_sweep();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_conv_seq.md
TEMP_CONV_SEQ -- requirements
Module: temp_conv_seq

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-003 SHALL have port: in_valid  input  1  celsius_in holds a valid sample.
REQ-004 SHALL have port: in_ready  output  1  block accepts a sample this cycle.
REQ-005 SHALL have port: celsius_in  input  8  signed two's-complement Celsius, -128..127.
REQ-006 SHALL have port: out_valid  output  1  fahrenheit_out holds a result.
REQ-007 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-008 SHALL have port: fahrenheit_out  output  10  signed Fahrenheit result, -198..260.
REQ-009 SHALL have port: conv_count  output  16  number of results delivered, saturating.

Function
REQ-010 SHALL compute fahrenheit_out = trunc0(celsius_in*9/5) + 32, where trunc0 truncates toward zero.
REQ-011 SHALL multiply the magnitude |C| by 9 into an 11-bit unsigned dividend, divide by 5 unsigned, reapply the sign of C, then add 32.
REQ-012 SHALL register the input sign and magnitude in the accept cycle; celsius_in is ignored outside the accept cycle.
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX, OUT.
REQ-014 IDLE: in_ready=1; in_valid=1 -> MUL on the same edge (accept edge).
REQ-015 MUL: forms |C|*9 and loads the divider with iteration count 10; -> DIV.
REQ-016 DIV: one restoring-division bit per cycle, 11 cycles; -> FIX after the iteration at count 0.
REQ-017 FIX: applies the sign and the +32 offset into the fahrenheit_out register; -> OUT.
REQ-018 OUT: out_valid=1; fahrenheit_out is held stable while out_ready=0; out_ready=1 -> IDLE and conv_count increments.
REQ-019 SHALL keep in_ready=0 in every state other than IDLE (no overlap; one sample per 15 cycles minimum).
REQ-020 Latency: out_valid SHALL rise on the 13th rising edge after the accept edge.
REQ-021 SHALL hold conv_count at 16'hFFFF once it is reached (no wrap).
REQ-022 SHALL treat C=0 and results of magnitude zero as positive (no -0 path).
REQ-023 SHALL have combinational outputs in_ready and out_valid decoded only from the state register.

Reset
REQ-024 rst=0 SHALL force state=IDLE, fahrenheit_out=0, conv_count=0, and clear divider registers, asynchronously.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no out_valid pulse; the first cycle after release shows in_ready=1.
REQ-026 Reset release SHALL be synchronous-safe; the first accept can occur on the first edge after release.

Structure
REQ-027 Package temp_conv_pkg SHALL hold the state enum typedef, constants MUL_K=9, DIV_K=5, F_OFFSET=32, DIVIDEND_W=11, OUT_W=10.
REQ-028 SHALL instantiate one sub-module, seq_divider: an 11-bit-by-3-bit unsigned restoring divider with start/done, quotient, and remainder outputs.
REQ-029 temp_conv_seq SHALL own the FSM, the sign handling, the offset adder, and conv_count; seq_divider owns the iteration counter.

Verification
REQ-030 C=0 accepted at edge 0 -> out_valid at edge 13, F=32, conv_count=1 after out_ready.
REQ-031 Sweep C=100, -40, 37, 127, -128 -> F=212, -40, 98, 260, -198 respectively.
REQ-032 Hold out_ready=0 for 20 cycles in OUT -> F stable, in_ready=0, conv_count unchanged; release -> conv_count+1, IDLE next cycle.
REQ-033 Assert rst during DIV (edge 6 after accept) -> no out_valid, F=0, conv_count unchanged-to-0; new C=-5 after release -> F=23.
REQ-034 Preload conv_count near saturation (force 16'hFFFE), perform 3 conversions -> conv_count=16'hFFFF and held.
REQ-035 in_valid=1 continuously with a changing celsius_in -> only values present on accept edges are converted, 15-cycle spacing with out_ready=1.
